// File: rtl/generatore_impulsi_pkg.sv
// Shared types for the pulse-train generator.
// State encoding and gap counter sizing.
package generatore_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic int gap_w(input int gap);
    int w;
    w = $clog2(gap + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/generatore_impulsi_if.sv
// Request/status bundle of the pulse-train generator.
// Master drives start/valore, slave drives the pulse outputs.
interface generatore_if #(
  parameter int N = 2
);
  logic         start;
  logic [N-1:0] valore;
  logic         impulso;
  logic         busy;
  logic         done;
  logic [N-1:0] rimanenti;

  modport master (
    output start, valore,
    input  impulso, busy, done, rimanenti
  );

  modport slave (
    input  start, valore,
    output impulso, busy, done, rimanenti
  );
endinterface

// File: rtl/generatore_impulsi_contatore_giu.sv
// Loadable down-counter with zero flag.
// Decrement saturates at zero so the count never wraps.
module contatore_giu #(
  parameter int W = 2
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         zero
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dout <= '0;
    end else if (load) begin
      dout <= din;
    end else if (dec && dout != '0) begin
      dout <= dout - W'(1);
    end
  end

  assign zero = (dout == '0);

endmodule

// File: rtl/generatore_impulsi.sv
// Pulse-train generator: emits valore one-cycle pulses
// spaced by GAP idle cycles, then a one-cycle done strobe.
module generatore_impulsi
  import generatore_pkg::*;
#(
  parameter int N   = 2,
  parameter int GAP = 1
) (
  input logic       clock,
  input logic       reset_n,
  generatore_if.slave bus
);

  localparam int GW = gap_w(GAP);
  localparam int GL = (GAP > 0) ? GAP - 1 : 0;

  state_t state, state_n;

  logic          r_load, r_dec, r_zero;
  logic          g_load, g_dec, g_zero;
  logic [N-1:0]  r_cnt;
  logic [GW-1:0] g_cnt;
  logic          unused_gcnt;

  contatore_giu #(.W(N)) u_rim (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (r_load),
    .dec     (r_dec),
    .din     (bus.valore),
    .dout    (r_cnt),
    .zero    (r_zero)
  );

  contatore_giu #(.W(GW)) u_gap (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (g_load),
    .dec     (g_dec),
    .din     (GW'(GL)),
    .dout    (g_cnt),
    .zero    (g_zero)
  );

  assign unused_gcnt = ^g_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    r_load  = 1'b0;
    r_dec   = 1'b0;
    g_load  = 1'b0;
    g_dec   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          r_load  = 1'b1;
          state_n = (bus.valore != '0) ? S_HIGH : S_DONE;
        end
      end
      S_HIGH: begin
        r_dec = 1'b1;
        if (r_zero || r_cnt == N'(1)) begin
          state_n = S_DONE;
        end else if (GAP == 0) begin
          state_n = S_HIGH;
        end else begin
          state_n = S_LOW;
          g_load  = 1'b1;
        end
      end
      S_LOW: begin
        if (g_zero) begin
          state_n = S_HIGH;
        end else begin
          g_dec = 1'b1;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // During a gap the pulse just emitted still counts as unfinished.
  assign bus.impulso   = (state == S_HIGH);
  assign bus.busy      = (state == S_HIGH) || (state == S_LOW);
  assign bus.done      = (state == S_DONE);
  assign bus.rimanenti = r_cnt + N'(state == S_LOW);

endmodule
